hash_table_arbiter: RTL

- Shares one hash_table command/response channel between NUM_REQ independent requesters.
- Round-robin arbitration on the command side, one registered command stage toward the table.
- An in-order tag FIFO of requester IDs routes each 32-bit table response back to the requester that issued it.
- Sits between the requester fabric and the axi_wrapper-style table port (packed {op[1:0], key, data} in, 32-bit status/data out).

---
 rtl/hash_table_pkg.sv | 24 ++
 rtl/hash_table_arbiter_rr_arbiter.sv | 44 ++++
 rtl/hash_table_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hash_table_pkg.sv
// Shared types and constants for the hash_table command/response channel and its arbiter.
package hash_table_pkg;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;

   localparam int RSP_W = 32;
   localparam int RSP_NO_DELETION_TARGET_BIT = 28;
   localparam int RSP_NO_WRITE_SPACE_BIT     = 29;
   localparam int RSP_NO_ELEMENT_FOUND_BIT   = 30;
   localparam int RSP_KEY_ALREADY_PRESENT_BIT = 31;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // A single requester still needs a one-bit ID so that port widths stay legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hash_table_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr_i, wrapping at NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [ID_W-1:0]    ptr_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   localparam int SUM_W = ID_W + 1;

   logic [NUM_REQ-1:0] rot_s;
   logic [ID_W-1:0]    off_s;
   logic [SUM_W-1:0]   sum_s;
   logic               found_s;

   // Rotate so bit 0 is the pointer position, then find the first set bit.
   always_comb begin
      rot_s   = NUM_REQ'({req_i, req_i} >> ptr_i);
      off_s   = '0;
      found_s = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rot_s[k] && !found_s) begin
            found_s = 1'b1;
            off_s   = ID_W'(k);
         end else begin
            found_s = found_s;
         end
      end
      sum_s = {1'b0, ptr_i} + {1'b0, off_s};
      if (sum_s >= SUM_W'(NUM_REQ)) begin
         sum_s = sum_s - SUM_W'(NUM_REQ);
      end else begin
         sum_s = sum_s;
      end
      idx_o = sum_s[ID_W-1:0];
      any_o = found_s;
      gnt_o = found_s ? (NUM_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/hash_table_arbiter.sv
// Shares one hash_table command/response port among NUM_REQ requesters with in-order response routing.
// Optional grant / FIFO-full statistics are built when HT_ARB_STATS_EN is defined.
module hash_table_arbiter
   import hash_table_pkg::*;
#(
   parameter int KEY_WIDTH       = 15,
   parameter int DATA_WIDTH      = 15,
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 8,
   localparam int CMD_W = 2 + DATA_WIDTH + KEY_WIDTH,
   localparam int ID_W  = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*CMD_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]       rsp_valid_o,
   input  logic [NUM_REQ-1:0]       rsp_ready_i,
   output logic [RSP_W-1:0]         rsp_data_o,
   output logic                     tbl_valid_o,
   input  logic                     tbl_ready_i,
   output logic [CMD_W-1:0]         tbl_data_o,
   input  logic                     tbl_valid_i,
   output logic                     tbl_ready_o,
   input  logic [RSP_W-1:0]         tbl_data_i
`ifdef HT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]    stat_grant_o,
   output logic [15:0]              stat_fifo_full_o
`endif
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CMD_W-1:0] tbl_data_q, tbl_data_d;
   logic [ID_W-1:0]  tag_q [MAX_OUTSTANDING];
   logic [ID_W-1:0]  tag_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [NUM_REQ-1:0] arb_gnt_s;
   logic [ID_W-1:0]    arb_idx_s;
   logic               arb_any_s;
   logic               fifo_full_s, fifo_empty_s, grant_s, pop_s;
   logic [ID_W-1:0]    head_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
      .ptr_i(rr_ptr_q),
      .req_i(req_valid_i),
      .gnt_o(arb_gnt_s),
      .idx_o(arb_idx_s),
      .any_o(arb_any_s)
   );

   // Grant and response routing; a pop this cycle never frees a slot for this cycle's grant.
   always_comb begin
      fifo_full_s  = (count_q == CNT_W'(MAX_OUTSTANDING));
      fifo_empty_s = (count_q == '0);
      head_s       = tag_q[rd_ptr_q];
      grant_s      = ((state_q == IDLE) || tbl_ready_i) && !fifo_full_s && arb_any_s;
      req_ready_o  = (grant_s && reset) ? arb_gnt_s : '0;
      rsp_data_o   = tbl_data_i;
      rsp_valid_o  = (tbl_valid_i && !fifo_empty_s) ? (NUM_REQ'(1) << head_s) : '0;
      tbl_ready_o  = !fifo_empty_s && rsp_ready_i[head_s];
      pop_s        = tbl_valid_i && tbl_ready_o;
      tbl_valid_o  = (state_q == HOLD);
      tbl_data_o   = tbl_data_q;
   end

   // Command FSM, round-robin pointer and tag FIFO next state.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      tbl_data_d = tbl_data_q;
      tag_d      = tag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (grant_s) begin
         state_d         = HOLD;
         rr_ptr_d        = (arb_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx_s + 1'b1;
         tbl_data_d      = req_data_i[arb_idx_s*CMD_W +: CMD_W];
         tag_d[wr_ptr_q] = arb_idx_s;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end else if ((state_q == HOLD) && tbl_ready_i) begin
         state_d = IDLE;
      end else begin
         state_d = state_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(grant_s) - CNT_W'(pop_s);
   end

   // State registers; reset discards any in-flight command and all outstanding tags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         tbl_data_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         tbl_data_q <= tbl_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tag_q      <= tag_d;
      end
   end

`ifdef HT_ARB_STATS_EN
   logic [15:0] stat_grant_q [NUM_REQ];
   logic [15:0] stat_grant_d [NUM_REQ];
   logic [15:0] stat_full_q, stat_full_d;

   // Saturating counters: grants per requester and cycles blocked by a full tag FIFO.
   always_comb begin
      stat_grant_d = stat_grant_q;
      stat_full_d  = stat_full_q;
      if (grant_s && (stat_grant_q[arb_idx_s] != 16'hFFFF)) begin
         stat_grant_d[arb_idx_s] = stat_grant_q[arb_idx_s] + 16'd1;
      end else begin
         stat_grant_d = stat_grant_q;
      end
      if (fifo_full_s && (|req_valid_i) && (stat_full_q != 16'hFFFF)) begin
         stat_full_d = stat_full_q + 16'd1;
      end else begin
         stat_full_d = stat_full_q;
      end
      stat_grant_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_grant_o[i*16 +: 16] = stat_grant_q[i];
      end
      stat_fifo_full_o = stat_full_q;
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_full_q <= 16'd0;
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_grant_q[i] <= 16'd0;
         end
      end else begin
         stat_full_q  <= stat_full_d;
         stat_grant_q <= stat_grant_d;
      end
   end
`endif

endmodule
